// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small in-order FIFO and drain in idle slots, with a starvation stall request.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_we_w,
    input  logic [4:0]               i_wb_rd_w,
    input  logic [31:0]              i_wb_data_w,
    input  logic                     i_mdu_valid,
    input  logic [4:0]               i_mdu_rd,
    input  logic [31:0]              i_mdu_data,
    output logic                     o_mdu_ready,
    output logic                     o_rf_we,
    output logic [4:0]               o_rf_rd,
    output logic [31:0]              o_rf_data,
    output logic                     o_stall_req,
    output logic [31:0]              o_pending_mask,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [3:0]    LIMIT = 4'(STARVE_LIMIT);

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [3:0]    starve;
    logic [3:0]    starve_next;
    logic          stall;
    logic          live;
    logic          ready;
    logic          push;
    logic          pop;

    assign live  = i_wb_we_w && (i_wb_rd_w != 5'd0);
    // Ready comes from the registered count only, so a full FIFO never pops through.
    assign ready = !i_rst && (count < FULL);
    assign push  = i_mdu_valid && ready && (i_mdu_rd != 5'd0);

    assign o_mdu_ready  = ready;
    assign o_stall_req  = stall;
    assign o_fifo_count = count;

    always_comb begin
        o_rf_we   = 1'b0;
        o_rf_rd   = '0;
        o_rf_data = '0;
        pop       = 1'b0;
        if (!i_rst) begin
            if (live) begin
                o_rf_we   = 1'b1;
                o_rf_rd   = i_wb_rd_w;
                o_rf_data = i_wb_data_w;
            end else if (count != '0) begin
                o_rf_we   = 1'b1;
                o_rf_rd   = q_rd[rd_ptr];
                o_rf_data = q_data[rd_ptr];
                pop       = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // A non-empty FIFO that is not popping means the pipeline holds the port.
    always_comb begin
        starve_next = starve;
        if (pop || (count == '0)) begin
            starve_next = '0;
        end else if (live && (starve != LIMIT)) begin
            starve_next = starve + 1'b1;
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        o_pending_mask = '0;
        off            = '0;
        if (!i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rd_ptr;
                if (CW'(off) < count) begin
                    o_pending_mask = o_pending_mask | (32'd1 << q_rd[i]);
                end
            end
            if (i_mdu_valid) begin
                o_pending_mask = o_pending_mask | (32'd1 << i_mdu_rd);
            end
            o_pending_mask[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
            stall  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count  <= count_next;
            starve <= starve_next;
            // One-cycle pulse; a saturated counter (ignored stall) re-pulses every other cycle.
            stall  <= (starve_next == LIMIT) && !stall;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= i_mdu_rd;
            q_data[wr_ptr] <= i_mdu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [31:0] pending_mask;
    logic [1:0]  fifo_count;

    int vectors = 0;
    int miscompares = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wb_we_w      (wb_we),
        .i_wb_rd_w      (wb_rd),
        .i_wb_data_w    (wb_data),
        .i_mdu_valid    (mdu_valid),
        .i_mdu_rd       (mdu_rd),
        .i_mdu_data     (mdu_data),
        .o_mdu_ready    (mdu_ready),
        .o_rf_we        (rf_we),
        .o_rf_rd        (rf_rd),
        .o_rf_data      (rf_data),
        .o_stall_req    (stall_req),
        .o_pending_mask (pending_mask),
        .o_fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        chk(tag, {rf_we, rf_rd, rf_data}, {we, rd, data});
    endtask

    initial begin
        int          mcount;
        int          pushed;
        int          samecnt;
        int          cyc;
        bit          mlive;
        bit          mpop;
        bit          mpush;
        logic [4:0]  exp_rd[$];
        logic [31:0] exp_data[$];
        logic [15:0] pat;
        logic [37:0] expect_port;

        // Reset held three cycles while both sources are active
        rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1111_1111;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rf_we", rf_we, 0);
            chk("rst_ready", mdu_ready, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_mask", pending_mask, 0);
            chk("rst_stall", stall_req, 0);
        end
        rst = 1'b0; wb_we = 1'b0; mdu_valid = 1'b0;
        #1;
        chk("post_rst_ready", mdu_ready, 1);
        chk("post_rst_count", fifo_count, 0);
        chk_port("post_rst_port", 1'b0, 5'd0, 32'd0);

        // Idle drain
        mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hDEAD_BEEF;
        #1;
        chk("idle_offer_mask", pending_mask, 32'h0000_0020);
        chk_port("idle_offer_port", 1'b0, 5'd0, 32'd0);
        tick();
        mdu_valid = 1'b0;
        #1;
        chk_port("idle_drain_port", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("idle_drain_mask", pending_mask, 32'h0000_0020);
        tick();
        chk("idle_after_count", fifo_count, 0);
        chk("idle_after_mask", pending_mask, 0);
        chk_port("idle_after_port", 1'b0, 5'd0, 32'd0);

        // Priority and full
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h101;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA;
        #1;
        chk_port("prio_rd1", 1'b1, 5'd1, 32'h101);
        tick();
        wb_rd = 5'd2; wb_data = 32'h102; mdu_rd = 5'd11; mdu_data = 32'hB;
        #1;
        chk_port("prio_rd2", 1'b1, 5'd2, 32'h102);
        chk("prio_count1", fifo_count, 1);
        chk("prio_mask_offer", pending_mask, 32'h0000_0C00);
        tick();
        wb_rd = 5'd3; wb_data = 32'h103; mdu_valid = 1'b0;
        #1;
        chk("full_count", fifo_count, 2);
        chk("full_ready", mdu_ready, 0);
        chk("full_mask", pending_mask, 32'h0000_0C00);
        mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC;
        #1;
        chk("full_mask_offer", pending_mask, 32'h0000_1C00);
        tick();
        wb_rd = 5'd4; wb_data = 32'h104;
        #1;
        chk("held_count_p2", fifo_count, 2);
        chk("held_stall_p2", stall_req, 0);
        tick();
        wb_rd = 5'd5; wb_data = 32'h105;
        #1;
        chk("held_count_p3", fifo_count, 2);
        chk("held_stall_p3", stall_req, 0);
        tick();
        wb_rd = 5'd6; wb_data = 32'h106;
        #1;
        chk("full_stall_p4", stall_req, 1);
        chk_port("full_port_p4", 1'b1, 5'd6, 32'h106);
        tick();
        wb_we = 1'b0;
        #1;
        chk_port("full_drain10", 1'b1, 5'd10, 32'hA);
        chk("full_stall_p5", stall_req, 0);
        chk("full_ready_p5", mdu_ready, 0);
        tick();
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h107;
        #1;
        chk("full_count_p6", fifo_count, 1);
        chk("full_ready_p6", mdu_ready, 1);
        chk_port("full_port_p6", 1'b1, 5'd7, 32'h107);
        tick();
        wb_rd = 5'd8; wb_data = 32'h108; mdu_valid = 1'b0;
        #1;
        chk("full_count_p7", fifo_count, 2);
        chk("full_mask_p7", pending_mask, 32'h0000_1800);
        tick();
        wb_we = 1'b0;
        #1;
        chk_port("full_drain11", 1'b1, 5'd11, 32'hB);
        tick();
        chk_port("full_drain12", 1'b1, 5'd12, 32'hC);
        tick();
        chk("full_empty", fifo_count, 0);

        // Starvation with compliant pipeline
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h201;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h1010;
        tick();
        mdu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("starve_quiet", stall_req, 0);
            tick();
        end
        chk("starve_stall", stall_req, 1);
        chk("starve_count", fifo_count, 1);
        tick();
        wb_we = 1'b0;
        #1;
        chk("starve_stall_off", stall_req, 0);
        chk_port("starve_drain", 1'b1, 5'd10, 32'h1010);
        tick();
        chk("starve_after_stall", stall_req, 0);
        chk("starve_after_count", fifo_count, 0);

        // Starvation with pipeline ignoring the stall once
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h202;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0909;
        tick();
        mdu_valid = 1'b0;
        repeat (4) tick();
        chk("viol_stall1", stall_req, 1);
        tick();
        chk("viol_gap", stall_req, 0);
        chk_port("viol_pipe_wins", 1'b1, 5'd2, 32'h202);
        tick();
        chk("viol_stall2", stall_req, 1);
        tick();
        wb_we = 1'b0;
        #1;
        chk_port("viol_drain", 1'b1, 5'd9, 32'h0909);
        tick();
        chk("viol_empty", fifo_count, 0);

        // x0 handling
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hBAD0_BAD0;
        #1;
        chk("x0_ready", mdu_ready, 1);
        chk("x0_mask", pending_mask, 0);
        tick();
        mdu_valid = 1'b0;
        #1;
        chk("x0_count", fifo_count, 0);
        chk_port("x0_nowrite", 1'b0, 5'd0, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h302;
        mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_data = 32'h1313;
        tick();
        mdu_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h300;
        #1;
        chk_port("x0_wb_rd0", 1'b1, 5'd13, 32'h1313);
        tick();
        chk("x0_wb_empty", fifo_count, 0);

        // Reset mid-operation discards queued entries
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h404;
        mdu_valid = 1'b1; mdu_rd = 5'd14; mdu_data = 32'h1414;
        tick();
        chk("midrst_count_before", fifo_count, 1);
        rst = 1'b1; wb_we = 1'b0; mdu_rd = 5'd15;
        #1;
        chk_port("midrst_nowrite", 1'b0, 5'd0, 32'd0);
        chk("midrst_ready", mdu_ready, 0);
        tick();
        rst = 1'b0; mdu_valid = 1'b0;
        #1;
        chk("midrst_count", fifo_count, 0);
        chk_port("midrst_after", 1'b0, 5'd0, 32'd0);

        // Wrap and ordering with mixed pipeline traffic
        mcount = 0; pushed = 0; samecnt = 0; cyc = 0;
        pat = 16'b1011_0100_1101_0010;
        while (!(pushed == 10 && mcount == 0) && cyc < 100) begin
            mdu_valid = (pushed < 10);
            mdu_rd    = 5'(pushed + 1);
            mdu_data  = 32'hC0DE_0000 + 32'(pushed + 1);
            wb_we     = pat[cyc % 16];
            wb_rd     = (cyc % 4 == 3) ? 5'd0 : 5'(17 + cyc % 8);
            wb_data   = 32'hABC0_0000 + 32'(cyc);
            #1;
            mlive = wb_we && (wb_rd != 5'd0);
            if (mlive) expect_port = {1'b1, wb_rd, wb_data};
            else if (mcount > 0) expect_port = {1'b1, exp_rd[0], exp_data[0]};
            else expect_port = '0;
            chk_port("wrap_port", expect_port[37], expect_port[36:32], expect_port[31:0]);
            chk("wrap_count", fifo_count, 64'(mcount));
            mpop  = !mlive && (mcount > 0);
            mpush = mdu_valid && (mcount < 2);
            if (mpop) begin
                void'(exp_rd.pop_front());
                void'(exp_data.pop_front());
            end
            if (mpush) begin
                exp_rd.push_back(mdu_rd);
                exp_data.push_back(mdu_data);
                pushed++;
            end
            if (mpop && mpush) samecnt++;
            mcount = mcount + int'(mpush) - int'(mpop);
            tick();
            cyc++;
        end
        mdu_valid = 1'b0; wb_we = 1'b0;
        #1;
        chk("wrap_done", (pushed == 10 && mcount == 0), 1);
        chk("wrap_final_count", fifo_count, 0);
        chk("wrap_pushpop_seen", (samecnt > 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
